// File: rtl/hazard_if.sv
// Hazard controller control bundle: pipeline state in from ID/EX and fetch,
// stall/flush controls back out to the pipeline registers.
interface hazard_if;
  logic [4:0] rs1_d;
  logic [4:0] rs2_d;
  logic [4:0] rd_e;
  logic       mem_read_e;
  logic       pc_src_e;
  logic       imem_ready;
  logic       stall_f;
  logic       stall_d;
  logic       flush_d;
  logic       flush_e;

  modport master (
    output rs1_d, rs2_d, rd_e, mem_read_e, pc_src_e, imem_ready,
    input  stall_f, stall_d, flush_d, flush_e
  );
  modport slave (
    input  rs1_d, rs2_d, rd_e, mem_read_e, pc_src_e, imem_ready,
    output stall_f, stall_d, flush_d, flush_e
  );
endinterface

// File: rtl/hazard_controller.sv
// Stall/flush sequencer for the 5-stage core: load-use, EX redirects, imem
// wait states, and discard of a wrong-path fetch still in flight (DRAIN).
module hazard_controller #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  hazard_if.slave          hz,
  output logic             drain,
  output logic [CNT_W-1:0] load_use_cnt,
  output logic [CNT_W-1:0] redirect_cnt,
  output logic [CNT_W-1:0] imem_wait_cnt
);
  typedef enum logic {RUN, DRAIN} state_t;

  state_t state, state_nx;
  logic   load_use;
  logic   lu_hit, wait_hit, redir_hit;

  assign load_use = hz.mem_read_e && (hz.rd_e != 5'd0) &&
                    ((hz.rd_e == hz.rs1_d) || (hz.rd_e == hz.rs2_d));

  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_nx;
  end

  assign drain = (state == DRAIN);

  always_comb begin
    state_nx   = state;
    hz.stall_f = 1'b0;
    hz.stall_d = 1'b0;
    hz.flush_d = 1'b0;
    hz.flush_e = 1'b0;
    lu_hit     = 1'b0;
    wait_hit   = 1'b0;
    redir_hit  = 1'b0;
    if (reset) begin
      hz.flush_d = 1'b1;
      hz.flush_e = 1'b1;
      state_nx   = RUN;
    end else begin
      unique case (state)
        RUN: begin
          if (hz.pc_src_e) begin
            hz.flush_d = 1'b1;
            hz.flush_e = 1'b1;
            redir_hit  = 1'b1;
            // target request may not land this cycle; whatever returns next is stale
            if (!hz.imem_ready) state_nx = DRAIN;
          end else if (load_use) begin
            hz.stall_f = 1'b1;
            hz.stall_d = 1'b1;
            hz.flush_e = 1'b1;
            lu_hit     = 1'b1;
          end else if (!hz.imem_ready) begin
            hz.stall_f = 1'b1;
            hz.flush_d = 1'b1;
            wait_hit   = 1'b1;
          end
        end
        DRAIN: begin
          hz.flush_d = 1'b1;
          wait_hit   = 1'b1;
          if (hz.pc_src_e) begin
            hz.flush_e = 1'b1;
            redir_hit  = 1'b1;
          end else begin
            hz.stall_f = 1'b1;
            if (hz.imem_ready) state_nx = RUN;
          end
        end
        default: state_nx = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      load_use_cnt  <= '0;
      redirect_cnt  <= '0;
      imem_wait_cnt <= '0;
    end else begin
      if (lu_hit)    load_use_cnt  <= load_use_cnt  + CNT_W'(1);
      if (redir_hit) redirect_cnt  <= redirect_cnt  + CNT_W'(1);
      if (wait_hit)  imem_wait_cnt <= imem_wait_cnt + CNT_W'(1);
    end
  end
endmodule

// File: doc/hazard_controller.md
# hazard_controller

Pipeline hazard sequencer for the 5-stage RISC-V core. It drives the stall and flush controls of the IF/ID register (`stall_d`, `flush_d`), the PC register (`stall_f`) and the ID/EX register (`flush_e`). It resolves three hazards:
- load-use data hazards;
- taken branch/jump redirects from EX;
- instruction-memory wait states, including discarding a stale fetch that was in flight when a redirect occurred.

It also keeps hazard performance counters.

## Interface
Parameters:
- CNT_W, 32, width of each performance counter

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  reset, synchronous, active-high
- rs1_d  in  5  source register 1 of the instruction in ID
- rs2_d  in  5  source register 2 of the instruction in ID
- rd_e  in  5  destination register of the instruction in EX
- mem_read_e  in  1  instruction in EX is a load
- pc_src_e  in  1  taken branch/jump resolved in EX this cycle
- imem_ready  in  1  instruction memory returns valid `inst_f` this cycle
- stall_f  out  1  hold the PC register
- stall_d  out  1  hold the IF/ID register
- flush_d  out  1  load a NOP bubble into IF/ID
- flush_e  out  1  load a bubble into ID/EX
- drain  out  1  FSM is in DRAIN
- load_use_cnt  out  CNT_W  cycles stalled for load-use
- redirect_cnt  out  CNT_W  redirects taken
- imem_wait_cnt  out  CNT_W  cycles with fetch held for memory wait or drain

## Operation
- `load_use` = `mem_read_e` & (`rd_e` != 0) & (`rd_e` == `rs1_d` | `rd_e` == `rs2_d`).
- FSM states: RUN, DRAIN.
- RUN output rules, in priority order; all other outputs are 0:
  1. `pc_src_e`: `flush_d`=1, `flush_e`=1, `stall_f`=0. The PC takes the target. If `imem_ready`=0, next state is DRAIN, else RUN.
  2. `load_use`: `stall_f`=1, `stall_d`=1, `flush_e`=1. This applies regardless of `imem_ready`.
  3. `!imem_ready`: `stall_f`=1, `flush_d`=1. A bubble enters ID while the older instructions advance.
  4. Otherwise all outputs are 0.
- DRAIN: the in-flight fetch belongs to the wrong path and is discarded.
  - `stall_f`=1, `flush_d`=1, `drain`=1.
  - `load_use` is ignored (ID holds a NOP).
  - When `imem_ready`=1, the stale word is discarded and next state is RUN. The PC still holds the target, so it is re-requested.
  - If `pc_src_e`=1 in DRAIN: `flush_d`=1, `flush_e`=1, `stall_f`=0, and the FSM stays in DRAIN.
- `stall_d` and `flush_d` are never both 1.
- Counters increment by 1 on the rising edge after a qualifying cycle, and wrap modulo 2^CNT_W:
  - `load_use_cnt`: rule 2 active.
  - `redirect_cnt`: `pc_src_e`=1, in any state.
  - `imem_wait_cnt`: rule 3 active, or state is DRAIN.
- While `reset`=1:
  - Outputs forced to `stall_f`=0, `stall_d`=0, `flush_d`=1, `flush_e`=1.
  - On the edge, state goes to RUN and all counters go to 0.
- Reset asserted in DRAIN returns the FSM to RUN. The memory subsystem is reset by the same signal, so there is no stale word.

## Timing
- `stall_f`, `stall_d`, `flush_d` and `flush_e` are combinational from the inputs plus the state register, valid in the same cycle. The pipeline registers sample them on the next rising edge.
- Latency:
  - Load-use: exactly 1 stall cycle per dependent pair. Next cycle, `mem_read_e`=0 because EX holds a bubble.
  - Redirect: 2 bubbles (ID and EX flushed in the redirect cycle).
- FSM transitions occur on the rising edge only.
- `drain` is registered, reflecting the current state.
- Counters are registered.
- No combinational path from any counter to any control output.

## Test plan
- Load-use: `mem_read_e`=1, `rd_e`=5, `rs1_d`=5, `imem_ready`=1 for one cycle -> `stall_f`=1, `stall_d`=1, `flush_e`=1, `flush_d`=0; `load_use_cnt` goes 0->1. Repeat with `rd_e`=0 -> all outputs 0.
- Branch + load-use same cycle: `pc_src_e`=1, `load_use` condition true -> `flush_d`=1, `flush_e`=1, `stall_f`=0, `stall_d`=0; `redirect_cnt`=1, `load_use_cnt`=0.
- Memory wait: `imem_ready`=0 for 3 cycles, then 1 -> `stall_f`=1 and `flush_d`=1 for 3 cycles, then all 0; `imem_wait_cnt`=3.
- Redirect during wait: `imem_ready`=0, `pc_src_e`=1 at cycle N; `imem_ready` stays 0 until N+3 -> `drain`=1 for N+1..N+3; `flush_d`=1 and `stall_f`=1 in N+1..N+3; RUN at N+4; `imem_wait_cnt`=3.
- Reset mid-DRAIN: enter DRAIN, assert `reset` one cycle -> `drain`=0 and counters=0 after the edge; during reset `flush_d`=1, `flush_e`=1, `stall_f`=0, `stall_d`=0.
- Counter wrap: CNT_W=4, 17 load-use cycles -> `load_use_cnt`=1.
